// File: rtl/obj_pkg.sv
// Shared types and helpers for the object scan sequencer: FSM state encoding,
// default widths and the saturating quotient resize.
package obj_pkg;

    localparam int ID_W_DEF    = 8;
    localparam int ACC_W_DEF   = 32;
    localparam int COORD_W_DEF = 11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DIV_X,
        DIV_Y,
        EMIT,
        DONE
    } scan_state_e;

    // Clamp q to the largest value representable in out_w bits.
    function automatic logic [63:0] sat_resize(input logic [63:0] q, input int unsigned out_w);
        logic [63:0] lim;
        lim = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
        return (q > lim) ? lim : q;
    endfunction

endpackage

// File: rtl/object_scan_sequencer_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, ACC_W cycles from start to done.
// The dividend carries one extra top bit that must be smaller than the divisor.
module seq_divider #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [ACC_W:0]   dividend_i,
    input  logic [ACC_W-1:0] divisor_i,
    output logic             done_o,
    output logic [ACC_W-1:0] quotient_o
);
    localparam int CW = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] rem_q;
    logic [ACC_W-1:0] q_q;
    logic [ACC_W-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;
    logic             done_q;

    logic [ACC_W-1:0] rem_in;
    logic [ACC_W-1:0] dvs_in;
    logic             bit_in;
    logic [ACC_W:0]   trial;
    logic [ACC_W-1:0] rem_nxt;
    logic             q_bit;

    // The start cycle already performs the first iteration, so done lands ACC_W cycles later.
    always_comb begin
        // NOTE: every combinational output is assigned on all paths to avoid latches.
        if (start_i) begin
            rem_in = {{(ACC_W-1){1'b0}}, dividend_i[ACC_W]};
            bit_in = dividend_i[ACC_W-1];
            dvs_in = divisor_i;
        end else begin
            rem_in = rem_q;
            bit_in = q_q[ACC_W-1];
            dvs_in = dvs_q;
        end
        trial = {rem_in, bit_in};
        if (trial >= {1'b0, dvs_in}) begin
            q_bit   = 1'b1;
            rem_nxt = ACC_W'(trial - {1'b0, dvs_in});
        end else begin
            q_bit   = 1'b0;
            rem_nxt = trial[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (reset) begin
            rem_q    <= '0;
            q_q      <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q    <= rem_nxt;
                q_q      <= {dividend_i[ACC_W-2:0], q_bit};
                dvs_q    <= divisor_i;
                cnt_q    <= CW'(ACC_W - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                rem_q <= rem_nxt;
                q_q   <= {q_q[ACC_W-2:0], q_bit};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = q_q;

endmodule

// File: rtl/object_scan_sequencer.sv
// Walks the connected-components table after each frame and streams one centroid per
// non-empty object. Optional round-half-up centroids under CENTROID_ROUND_EN.
module object_scan_sequencer
    import obj_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_done,
    input  logic [ID_W-1:0]    num_labels,
    output logic [ID_W-1:0]    obj_id,
    input  logic [ACC_W-1:0]   obj_area,
    input  logic [ACC_W-1:0]   obj_x,
    input  logic [ACC_W-1:0]   obj_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic [COORD_W-1:0] res_cx,
    output logic [COORD_W-1:0] res_cy,
    output logic [ACC_W-1:0]   res_area,
    output logic               busy,
    output logic               scan_done
);
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    scan_state_e        state_q;
    logic [ID_W-1:0]    n_lat_q;
    logic [ID_W-1:0]    obj_id_q;
    logic [WCW-1:0]     wait_cnt_q;
    logic [ACC_W-1:0]   area_q;
    logic [ACC_W-1:0]   x_q;
    logic [ACC_W-1:0]   y_q;
    logic [COORD_W-1:0] cx_q;
    logic               res_valid_q;
    logic [ID_W-1:0]    res_id_q;
    logic [COORD_W-1:0] res_cx_q;
    logic [COORD_W-1:0] res_cy_q;
    logic [ACC_W-1:0]   res_area_q;
    logic               busy_q;
    logic               scan_done_q;

    logic               div_start;
    logic               div_done;
    logic [ACC_W:0]     num_x;
    logic [ACC_W:0]     num_y;
    logic [ACC_W:0]     div_dividend;
    logic [ACC_W-1:0]   div_quotient;
    logic [COORD_W-1:0] div_sat;
    logic               last_obj;

`ifdef CENTROID_ROUND_EN
    // The carry out lands in the divider's extra dividend bit; it is below area when area >= 2.
    assign num_x = {1'b0, x_q} + {2'b00, area_q[ACC_W-1:1]};
    assign num_y = {1'b0, y_q} + {2'b00, area_q[ACC_W-1:1]};
`else
    assign num_x = {1'b0, x_q};
    assign num_y = {1'b0, y_q};
`endif

    assign div_start    = ((state_q == CHECK) && (area_q != '0)) || ((state_q == DIV_X) && div_done);
    assign div_dividend = (state_q == DIV_X) ? num_y : num_x;
    assign div_sat      = COORD_W'(sat_resize(64'(div_quotient), COORD_W));
    assign last_obj     = (obj_id_q == n_lat_q);

    seq_divider #(
        .ACC_W(ACC_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (area_q),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_lat_q     <= '0;
            obj_id_q    <= ID_W'(1);
            wait_cnt_q  <= '0;
            area_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cx_q        <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_cx_q    <= '0;
            res_cy_q    <= '0;
            res_area_q  <= '0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_done) begin
                        n_lat_q  <= num_labels;
                        obj_id_q <= ID_W'(1);
                        busy_q   <= 1'b1;
                        state_q  <= (num_labels != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q == WCW'(RD_LAT - 1)) begin
                        area_q  <= obj_area;
                        x_q     <= obj_x;
                        y_q     <= obj_y;
                        state_q <= CHECK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (area_q != '0) begin
                        state_q <= DIV_X;
                    end else if (last_obj) begin
                        scan_done_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        obj_id_q <= obj_id_q + ID_W'(1);
                        state_q  <= ISSUE;
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        cx_q    <= div_sat;
                        state_q <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        res_id_q    <= obj_id_q;
                        res_cx_q    <= cx_q;
                        res_cy_q    <= div_sat;
                        res_area_q  <= area_q;
                        res_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (last_obj) begin
                            scan_done_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            obj_id_q <= obj_id_q + ID_W'(1);
                            state_q  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    // An empty scan enters DONE without the pulse and raises it one cycle later.
                    if (scan_done_q) begin
                        scan_done_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        scan_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign obj_id    = obj_id_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_cx    = res_cx_q;
    assign res_cy    = res_cy_q;
    assign res_area  = res_area_q;
    assign busy      = busy_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_object_scan_sequencer.sv
// Self-checking bench for object_scan_sequencer: directed scenarios plus randomized tables
// compared against an arithmetic centroid model.
module tb_object_scan_sequencer;

    typedef struct packed {
        logic [7:0]  id;
        logic [10:0] cx;
        logic [10:0] cy;
        logic [31:0] area;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done = 1'b0;
    logic [7:0]  num_labels = '0;
    logic [7:0]  obj_id;
    logic [31:0] obj_area;
    logic [31:0] obj_x;
    logic [31:0] obj_y;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_id;
    logic [10:0] res_cx;
    logic [10:0] res_cy;
    logic [31:0] res_area;
    logic        busy;
    logic        scan_done;

    object_scan_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_done (frame_done),
        .num_labels (num_labels),
        .obj_id     (obj_id),
        .obj_area   (obj_area),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_cx     (res_cx),
        .res_cy     (res_cy),
        .res_area   (res_area),
        .busy       (busy),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data table with a two-cycle read pipeline.
    logic [31:0] t_area [256];
    logic [31:0] t_x    [256];
    logic [31:0] t_y    [256];
    logic [31:0] a1 = '0, a2 = '0, x1 = '0, x2 = '0, y1 = '0, y2 = '0;
    always @(posedge clk) begin
        a1 <= t_area[obj_id];
        a2 <= a1;
        x1 <= t_x[obj_id];
        x2 <= x1;
        y1 <= t_y[obj_id];
        y2 <= y1;
    end
    assign obj_area = a2;
    assign obj_x    = x2;
    assign obj_y    = y2;

    int   tests = 0;
    int   fails = 0;
    int   valid_cycles = 0;
    bit   rnd_ready = 1'b0;
    logic ready_force = 1'b1;
    res_t got_q[$];
    res_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive res_ready and log the handshake due at the next rise.
    task automatic tick();
        res_t r;
        @(negedge clk);
        res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
        if (res_valid) valid_cycles++;
        if (res_valid && res_ready && !reset) begin
            r = {res_id, res_cx, res_cy, res_area};
            got_q.push_back(r);
        end
    endtask

    function automatic logic [10:0] centroid(input longint unsigned sum, input longint unsigned area);
        longint unsigned q;
`ifdef CENTROID_ROUND_EN
        q = (sum + area / 2) / area;
`else
        q = sum / area;
`endif
        return (q > 2047) ? 11'd2047 : q[10:0];
    endfunction

    function automatic void build_exp(input int n);
        res_t r;
        for (int id = 1; id <= n; id++) begin
            if (t_area[id] != 0) begin
                r = {8'(id), centroid(t_x[id], t_area[id]), centroid(t_y[id], t_area[id]), t_area[id]};
                exp_q.push_back(r);
            end
        end
    endfunction

    function automatic void clear_table();
        for (int i = 0; i < 256; i++) begin
            t_area[i] = '0;
            t_x[i]    = '0;
            t_y[i]    = '0;
        end
    endfunction

    function automatic void set_obj(input int id, input logic [31:0] a, input logic [31:0] x, input logic [31:0] y);
        t_area[id] = a;
        t_x[id]    = x;
        t_y[id]    = y;
    endfunction

    task automatic compare_results(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_res%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Pulse frame_done, optionally pulse it again inj_at cycles later, and measure scan_done latency.
    task automatic run_scan(input int n, input int inj_at, output int dt);
        int t0;
        bit seen;
        tick();
        num_labels = 8'(n);
        frame_done = 1'b1;
        t0 = cyc;
        tick();
        frame_done = 1'b0;
        check("busy_after_frame", 64'(busy), 64'd1);
        seen = 1'b0;
        dt = -1;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (scan_done) begin
                seen = 1'b1;
                dt = cyc - t0;
            end else begin
                if (inj_at != 0 && (cyc - t0) == inj_at) begin
                    num_labels = 8'd5;
                    frame_done = 1'b1;
                end
                tick();
                frame_done = 1'b0;
            end
        end
        check("scan_done_seen", 64'(seen), 64'd1);
        tick();
        check("scan_done_one_cycle", {63'd0, scan_done}, 64'd0);
        check("busy_drops", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dt;
        int t0;
        int vc0;
        bit seen;
        res_t snap;
        logic [7:0] snap_id;

        clear_table();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst_obj_id", 64'(obj_id), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_res_cx", 64'(res_cx), 64'd0);
        check("rst_res_cy", 64'(res_cy), 64'd0);
        check("rst_res_area", 64'(res_area), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_scan_done", 64'(scan_done), 64'd0);

        // Single object, back-to-back ready: 70-cycle scan
        ready_force = 1'b1;
        set_obj(1, 32'd4, 32'd40, 32'd80);
        run_scan(1, 0, dt);
        check("t1_latency", 64'(dt), 64'd70);
        check("t1_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0)
            check("t1_result", 64'(got_q[0]), {2'b00, 8'd1, 11'd10, 11'd20, 32'd4});
        build_exp(1);
        compare_results("t1");

        // Deleted label skipped
        clear_table();
        set_obj(1, 32'd0, 32'd0, 32'd0);
        set_obj(2, 32'd3, 32'd10, 32'd8);
        run_scan(2, 0, dt);
        check("t2_latency", 64'(dt), 64'd74);
        build_exp(2);
        compare_results("t2");

        // Saturation, including a numerator at the top of the accumulator range
        clear_table();
        set_obj(1, 32'd1, 32'd5000, 32'd7);
        set_obj(2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        run_scan(2, 0, dt);
        if (got_q.size() > 0)
            check("t3_cx_sat", 64'(got_q[0].cx), 64'd2047);
        build_exp(2);
        compare_results("t3");

        // Backpressure: held result must stay bit-stable for 10 cycles
        clear_table();
        set_obj(1, 32'd2, 32'd100, 32'd61);
        ready_force = 1'b0;
        tick();
        tick();
        num_labels = 8'd1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (res_valid) seen = 1'b1;
            else tick();
        end
        check("t4_valid_seen", 64'(seen), 64'd1);
        snap = {res_id, res_cx, res_cy, res_area};
        snap_id = obj_id;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_hold_valid", 64'(res_valid), 64'd1);
            check("t4_hold_result", 64'({res_id, res_cx, res_cy, res_area}), 64'(snap));
            check("t4_hold_obj_id", 64'(obj_id), 64'(snap_id));
        end
        ready_force = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (scan_done) seen = 1'b1;
        end
        check("t4_scan_done_seen", 64'(seen), 64'd1);
        build_exp(1);
        compare_results("t4");

        // Empty frame, then a frame_done while busy
        vc0 = valid_cycles;
        run_scan(0, 0, dt);
        check("t5_empty_latency", 64'(dt), 64'd2);
        check("t5_no_valid", 64'(valid_cycles - vc0), 64'd0);
        clear_table();
        set_obj(1, 32'd5, 32'd55, 32'd23);
        set_obj(2, 32'd7, 32'd700, 32'd99);
        set_obj(3, 32'd9, 32'd90, 32'd90);
        run_scan(2, 30, dt);
        check("t5_busy_ignore_latency", 64'(dt), 64'd139);
        build_exp(2);
        compare_results("t5");

        // Reset during DIV_Y of object 2 of 3, then restart from object 1
        tick();
        num_labels = 8'd3;
        frame_done = 1'b1;
        t0 = cyc;
        tick();
        frame_done = 1'b0;
        for (int k = 0; k < 200 && (cyc - t0) < 110; k++) tick();
        check("t6_reset_point", 64'(cyc - t0), 64'd110);
        check("t6_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_obj_id", 64'(obj_id), 64'd1);
        check("t6_res_valid", 64'(res_valid), 64'd0);
        check("t6_res_fields", 64'({res_id, res_cx, res_cy, res_area}), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_scan_done", 64'(scan_done), 64'd0);
        check("t6_partial_count", 64'(got_q.size()), 64'd1);
        got_q.delete();
        run_scan(3, 0, dt);
        build_exp(3);
        compare_results("t6_restart");

        // Randomized tables with random backpressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            int n;
            clear_table();
            n = $urandom_range(1, 6);
            for (int id = 1; id <= n; id++) begin
                int unsigned a;
                a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
                if (a != 0)
                    set_obj(id, a, a * $urandom_range(0, 2500) + $urandom_range(0, a - 1),
                            a * $urandom_range(0, 2100) + $urandom_range(0, a - 1));
            end
            run_scan(n, 0, dt);
            build_exp(n);
            compare_results($sformatf("rnd%0d", s));
        end
        rnd_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
